// File: rtl/gpu_pkg.sv
// Shared definitions for the draw-op executor: op record, sprite texel layout, FSM states.
package gpu_pkg;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic [10:0] width;
      logic [10:0] height;
      logic        color;
      logic        mem_en;
      logic [11:0] mem_addr;
      logic        scale;
   } gpu_op_t;

   localparam int unsigned SPR_OPAQUE_BIT = 1;
   localparam int unsigned SPR_COLOR_BIT  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      DRAW  = 2'd2,
      DRAIN = 2'd3
   } gpu_state_e;

endpackage

// File: rtl/gpu_rect_walker.sv
// Rectangle iterator: walks dx/dy across an op and tracks framebuffer and sprite row bases.
module gpu_rect_walker
   import gpu_pkg::*;
#(
   parameter int unsigned HOR_ACTIVE_PIXELS = 640,
   parameter int unsigned FB_ADDR_WIDTH     = 19
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce,
   input  logic                     start_i,
   input  logic [10:0]              start_y_i,
   input  logic                     step_i,
   input  logic [10:0]              width_i,
   input  logic [10:0]              height_i,
   input  logic                     scale_i,
   output logic [10:0]              dx_o,
   output logic [10:0]              dy_o,
   output logic [FB_ADDR_WIDTH-1:0] row_base_o,
   output logic [11:0]              tex_row_base_o,
   output logic                     last_o
);

   logic [10:0]              dx_q, dx_d;
   logic [10:0]              dy_q, dy_d;
   logic [FB_ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [11:0]              tex_row_base_q, tex_row_base_d;
   logic                     row_end;
   logic [11:0]              stride;

   always_comb begin
      row_end        = (dx_q == width_i - 11'd1);
      last_o         = row_end && (dy_q == height_i - 11'd1);
      stride         = {1'b0, width_i} >> scale_i;
      dx_d           = dx_q;
      dy_d           = dy_q;
      row_base_d     = row_base_q;
      tex_row_base_d = tex_row_base_q;
      if (start_i) begin
         dx_d           = '0;
         dy_d           = '0;
         tex_row_base_d = '0;
         row_base_d     = FB_ADDR_WIDTH'(start_y_i) * FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
      end else if (step_i) begin
         if (row_end) begin
            dx_d       = '0;
            dy_d       = dy_q + 11'd1;
            row_base_d = row_base_q + FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);
            // at 2x a sprite row is reused for two screen rows: advance only after odd dy
            if (!scale_i || dy_q[0]) begin
               tex_row_base_d = tex_row_base_q + stride;
            end
         end else begin
            dx_d = dx_q + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dx_q           <= '0;
         dy_q           <= '0;
         row_base_q     <= '0;
         tex_row_base_q <= '0;
      end else if (ce) begin
         dx_q           <= dx_d;
         dy_q           <= dy_d;
         row_base_q     <= row_base_d;
         tex_row_base_q <= tex_row_base_d;
      end
   end

   assign dx_o           = dx_q;
   assign dy_o           = dy_q;
   assign row_base_o     = row_base_q;
   assign tex_row_base_o = tex_row_base_q;

endmodule

// File: rtl/gpu_op_executor.sv
// Draw-op executor: pops gpu_op_t records and rasterizes rectangles/sprites one pixel per cycle.
module gpu_op_executor
   import gpu_pkg::*;
#(
   parameter int unsigned HOR_ACTIVE_PIXELS = 640,
   parameter int unsigned VER_ACTIVE_PIXELS = 480,
   parameter int unsigned SPR_ADDR_WIDTH    = 12,
   parameter int unsigned FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ce,
   input  gpu_op_t                   op_in,
   input  logic                      op_empty,
   output logic                      op_rd_en,
   output logic [SPR_ADDR_WIDTH-1:0] spr_addr,
   input  logic [1:0]                spr_data,
   output logic                      fb_wr_en,
   output logic [FB_ADDR_WIDTH-1:0]  fb_wr_addr,
   output logic                      fb_wr_data,
   output logic                      busy
);

   gpu_state_e                state_q, state_d;
   gpu_op_t                   op_q, op_d;
   logic [SPR_ADDR_WIDTH-1:0] spr_addr_q, spr_addr_d;
   logic                      vis_q, vis_d;
   logic [FB_ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;

   logic [10:0]               dx, dy;
   logic [FB_ADDR_WIDTH-1:0]  row_base;
   logic [11:0]               tex_row_base;
   logic                      walk_last;
   logic [11:0]               px, py;

   gpu_rect_walker #(
      .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
      .FB_ADDR_WIDTH     (FB_ADDR_WIDTH)
   ) u_walker (
      .clk            (clk),
      .rst_n          (rst_n),
      .ce             (ce),
      .start_i        (state_q == LATCH),
      .start_y_i      (op_in.y),
      .step_i         (state_q == DRAW),
      .width_i        (op_q.width),
      .height_i       (op_q.height),
      .scale_i        (op_q.scale),
      .dx_o           (dx),
      .dy_o           (dy),
      .row_base_o     (row_base),
      .tex_row_base_o (tex_row_base),
      .last_o         (walk_last)
   );

   // pop strobe is combinational so the LATCH cycle already sees the FIFO read data
   assign op_rd_en = rst_n && ce && (state_q == IDLE) && !op_empty;

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      spr_addr_d = spr_addr_q;
      vis_d      = 1'b0;
      wr_addr_d  = wr_addr_q;
      px         = {1'b0, op_q.x} + {1'b0, dx};
      py         = {1'b0, op_q.y} + {1'b0, dy};
      case (state_q)
         IDLE: begin
            if (op_rd_en) state_d = LATCH;
         end
         LATCH: begin
            op_d    = op_in;
            state_d = (op_in.width == '0 || op_in.height == '0) ? DRAIN : DRAW;
         end
         DRAW: begin
            spr_addr_d = SPR_ADDR_WIDTH'(op_q.mem_addr) + SPR_ADDR_WIDTH'(tex_row_base)
                       + SPR_ADDR_WIDTH'(dx >> op_q.scale);
            vis_d      = (px < 12'(HOR_ACTIVE_PIXELS)) && (py < 12'(VER_ACTIVE_PIXELS));
            wr_addr_d  = row_base + FB_ADDR_WIDTH'(px);
            if (walk_last) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         op_q       <= '0;
         spr_addr_q <= '0;
         vis_q      <= 1'b0;
         wr_addr_q  <= '0;
      end else if (ce) begin
         state_q    <= state_d;
         op_q       <= op_d;
         spr_addr_q <= spr_addr_d;
         vis_q      <= vis_d;
         wr_addr_q  <= wr_addr_d;
      end
   end

   // stage B merges the texel returned for the registered address in the same cycle
   assign fb_wr_en   = vis_q && (!op_q.mem_en || spr_data[SPR_OPAQUE_BIT]);
   assign fb_wr_data = op_q.mem_en ? spr_data[SPR_COLOR_BIT] : op_q.color;
   assign fb_wr_addr = wr_addr_q;
   assign spr_addr   = spr_addr_q;
   assign busy       = op_rd_en || (state_q != IDLE);

endmodule

// File: tb/tb_gpu_op_executor.sv
// Self-checking bench for gpu_op_executor: FIFO/ROM models, per-pixel scoreboard, op table.
module tb_gpu_op_executor;
   import gpu_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b1;
   gpu_op_t       op_in = '0;
   logic          op_empty = 1'b1;
   logic          op_rd_en;
   logic [11:0]   spr_addr;
   logic [1:0]    spr_data;
   logic          fb_wr_en;
   logic [18:0]   fb_wr_addr;
   logic          fb_wr_data;
   logic          busy;

   gpu_op_executor #(
      .HOR_ACTIVE_PIXELS (640),
      .VER_ACTIVE_PIXELS (480),
      .SPR_ADDR_WIDTH    (12)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ce         (ce),
      .op_in      (op_in),
      .op_empty   (op_empty),
      .op_rd_en   (op_rd_en),
      .spr_addr   (spr_addr),
      .spr_data   (spr_data),
      .fb_wr_en   (fb_wr_en),
      .fb_wr_addr (fb_wr_addr),
      .fb_wr_data (fb_wr_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // sprite ROM: texel i = {i[0], i[1]}
   always_comb spr_data = {spr_addr[0], spr_addr[1]};

   typedef struct {
      int unsigned t;
      logic        chk_spr;
      logic [11:0] spr;
      logic        we;
      logic [18:0] addr;
      logic        d;
   } pix_t;

   typedef struct {
      gpu_op_t     op;
      int unsigned writes;
      int          first;
   } vec_t;

   pix_t        exp_q[$];
   gpu_op_t     fifo[$];
   int unsigned pop_t[$];
   int unsigned L = 0;
   int unsigned busy_end = 0;
   int unsigned n_tests = 0;
   int unsigned n_fail = 0;
   int unsigned n_writes = 0;
   int          first_wr = -1;
   logic        ce_rand = 1'b0;
   vec_t        vecs[8];

   function automatic gpu_op_t mk(int unsigned x, int unsigned y, int unsigned w, int unsigned h,
                                  logic color, logic mem_en, int unsigned mem_addr, logic scale);
      gpu_op_t o;
      o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
      o.color = color; o.mem_en = mem_en; o.mem_addr = 12'(mem_addr); o.scale = scale;
      return o;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, L);
      end
   endtask

   task automatic push_pixels(gpu_op_t op, int unsigned k);
      int unsigned s, px, py, tex;
      pix_t p;
      s = op.scale;
      for (int unsigned dy = 0; dy < op.height; dy++) begin
         for (int unsigned dx = 0; dx < op.width; dx++) begin
            px  = op.x + dx;
            py  = op.y + dy;
            tex = (op.mem_addr + (dy >> s) * (op.width >> s) + (dx >> s)) % 4096;
            p.t       = k + 3 + dy * op.width + dx;
            p.chk_spr = op.mem_en;
            p.spr     = 12'(tex);
            p.we      = (px < 640) && (py < 480) && (!op.mem_en || (tex & 1) == 1);
            p.addr    = 19'(py * 640 + px);
            p.d       = op.mem_en ? ((tex >> 1) & 1) == 1 : op.color;
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic push_op(gpu_op_t op);
      fifo.push_back(op);
      op_empty = 1'b0;
   endtask

   task automatic cycle();
      gpu_op_t popped;
      logic    do_load, exp_pop, exp_busy;
      pix_t    p;
      do_load = 1'b0;
      popped  = '0;
      @(negedge clk);
      if (!rst_n) begin
         check("reset_ctl", {28'd0, op_rd_en, fb_wr_en, fb_wr_data, busy}, 32'd0);
         check("reset_addr", {1'b0, spr_addr, fb_wr_addr}, 32'd0);
         exp_q.delete();
         busy_end = L;
      end else if (!ce) begin
         check("rd_en_ce_low", op_rd_en, 0);
      end else begin
         exp_pop  = (fifo.size() > 0) && (L >= busy_end);
         exp_busy = exp_pop || (L < busy_end);
         check("pop", op_rd_en, exp_pop);
         check("busy", busy, exp_busy);
         if (exp_q.size() > 0 && exp_q[0].t == L) begin
            p = exp_q.pop_front();
            check("wr_en", fb_wr_en, p.we);
            if (p.we) begin
               check("wr_addr", fb_wr_addr, p.addr);
               check("wr_data", fb_wr_data, p.d);
            end
            if (p.chk_spr) check("spr_addr", spr_addr, p.spr);
         end else begin
            check("idle_wr_en", fb_wr_en, 0);
         end
         if (fb_wr_en) begin
            n_writes++;
            if (first_wr < 0) first_wr = int'(fb_wr_addr);
         end
         if (op_rd_en) pop_t.push_back(L);
         if (exp_pop) begin
            popped = fifo.pop_front();
            push_pixels(popped, L);
            busy_end = L + popped.width * popped.height + 3;
            do_load  = 1'b1;
         end
         L++;
      end
      @(posedge clk);
      #1;
      if (do_load) op_in = popped;
      op_empty = (fifo.size() == 0);
      if (ce_rand) ce = ($urandom_range(0, 3) != 0);
   endtask

   task automatic run_idle(int unsigned budget);
      int unsigned n;
      n = 0;
      while ((fifo.size() > 0 || exp_q.size() > 0 || L < busy_end) && n < budget) begin
         cycle();
         n++;
      end
      check("drain_timeout", n >= budget, 0);
      ce_rand = 1'b0;
      ce = 1'b1;
      repeat (2) cycle();
   endtask

   initial begin
      vecs[0] = '{mk(620, 470, 40, 20, 1, 0, 0, 0), 200, 301420};
      vecs[1] = '{mk(20, 228, 34, 24, 0, 1, 0, 0), 408, 145941};
      vecs[2] = '{mk(0, 0, 4, 4, 0, 1, 0, 1), 8, 2};
      vecs[3] = '{mk(10, 10, 0, 5, 1, 0, 0, 0), 0, -1};
      vecs[4] = '{mk(639, 479, 1, 1, 1, 0, 0, 0), 1, 307199};
      vecs[5] = '{mk(0, 479, 640, 2, 0, 0, 0, 0), 640, 306560};
      vecs[6] = '{mk(2040, 0, 100, 1, 1, 0, 0, 0), 0, -1};
      vecs[7] = '{mk(100, 100, 4, 1, 0, 1, 4094, 0), 2, 64101};

      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();

      for (int i = 0; i < 8; i++) begin
         n_writes = 0;
         first_wr = -1;
         push_op(vecs[i].op);
         run_idle(4000);
         check($sformatf("vec%0d_writes", i), n_writes, vecs[i].writes);
         check($sformatf("vec%0d_first", i), first_wr, vecs[i].first);
      end

      // zero-size op followed by a 1x1: pops three cycles apart
      n_writes = 0;
      pop_t.delete();
      push_op(mk(5, 5, 0, 3, 1, 0, 0, 0));
      push_op(mk(5, 5, 1, 1, 1, 0, 0, 0));
      run_idle(100);
      check("b2b_pops", pop_t.size(), 2);
      if (pop_t.size() == 2) check("b2b_spacing", pop_t[1] - pop_t[0], 3);
      check("b2b_writes", n_writes, 1);

      // ce held low mid-op: identical sequence, only delayed
      n_writes = 0;
      push_op(mk(300, 200, 40, 40, 0, 1, 100, 1));
      repeat (200) cycle();
      ce = 1'b0;
      repeat (5) cycle();
      ce = 1'b1;
      run_idle(4000);
      check("ce_hold_writes", n_writes, 800);

      // random clock-enable over a whole sprite op
      n_writes = 0;
      push_op(mk(20, 228, 34, 24, 0, 1, 0, 0));
      ce_rand = 1'b1;
      run_idle(8000);
      check("ce_rand_writes", n_writes, 408);

      // reset during DRAW aborts the op
      push_op(mk(0, 0, 40, 40, 1, 0, 0, 0));
      repeat (300) cycle();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
      n_writes = 0;
      repeat (50) cycle();
      check("post_reset_writes", n_writes, 0);
      check("post_reset_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/gpu_op_executor.md
Name: gpu_op_executor

Overview:
- Consumer end of the draw-op FIFO that the game CPU fills with gpu_op_t records.
- Pops one op at a time and rasterizes it into the back framebuffer at one pixel per enabled cycle.
- An op is either a solid-colour rectangle or a sprite blit from sprite ROM, with optional 2x upscale and screen clipping.
- Sits between the op FIFO read port and the framebuffer write port.

Parameters:
- HOR_ACTIVE_PIXELS, 640, framebuffer width in pixels.
- VER_ACTIVE_PIXELS, 480, framebuffer height in pixels.
- SPR_ADDR_WIDTH, 12, sprite ROM address width; must equal the width of gpu_op_t.mem_addr.
- FB_ADDR_WIDTH, $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS), framebuffer address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state holds.
- op_in  in  gpu_op_t  FIFO read data; valid the cycle after op_rd_en.
- op_empty  in  1  FIFO empty.
- op_rd_en  out  1  FIFO pop strobe.
- spr_addr  out  SPR_ADDR_WIDTH  sprite ROM address; 1-cycle read latency.
- spr_data  in  2  sprite texel: bit1 = opaque, bit0 = colour.
- fb_wr_en  out  1  framebuffer write strobe.
- fb_wr_addr  out  FB_ADDR_WIDTH  pixel address, y*HOR_ACTIVE_PIXELS + x.
- fb_wr_data  out  1  pixel colour.
- busy  out  1  high from pop until the last write of the current op has retired.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low the state is IDLE and op_rd_en, fb_wr_en, fb_wr_data, fb_wr_addr, spr_addr and busy are all 0.
- Reset mid-op aborts the op with no further writes. The popped op is lost.
- All registers, outputs included, advance only when ce=1. The framebuffer must qualify fb_wr_en with ce.
- IDLE:
  - If !op_empty: op_rd_en<=1, busy<=1, go to LATCH.
  - Otherwise stay in IDLE.
- LATCH:
  - op_rd_en<=0.
  - Capture op_in into a working register. Clear dx, dy and tex_row_base. Set row_base = op.y*HOR_ACTIVE_PIXELS.
  - If width==0 or height==0, go to DRAIN. Otherwise go to DRAW.
- DRAW: one pixel per cycle in stage A.
  - Pixel coordinates: px = x+dx, py = y+dy.
  - Texel address: spr_addr <= mem_addr + tex_row_base + (dx>>scale).
  - Stage A registers px, py, the address (row_base + px) and a visible flag (px < HOR_ACTIVE_PIXELS && py < VER_ACTIVE_PIXELS) into stage B.
  - dx increments. At dx==width-1: dx<=0, dy increments, row_base += HOR_ACTIVE_PIXELS.
  - tex_row_base += width>>scale only when the next dy>>scale changes.
  - Sprite row stride is width>>scale.
  - At the last pixel (dx==width-1, dy==height-1), go to DRAIN.
- Stage B (one cycle after stage A): fb_wr_en <= visible && (!mem_en || spr_data[1]). fb_wr_data <= mem_en ? spr_data[0] : color.
- DRAIN: one cycle for stage B to retire. Then busy<=0 and go to IDLE.
- Latency, from pop to first write:
  - Cycle 0: op_rd_en.
  - Cycle 1: LATCH.
  - Cycle 2: first stage A.
  - Cycle 3: first fb_wr_en.
- A w×h op occupies w*h+3 cycles from pop to busy fall.
- Back-to-back ops: the next pop may occur in the cycle busy falls.
- Arithmetic:
  - All coordinate sums are 12-bit unsigned, so overflow past 2047 can never wrap onto the screen.
  - Clipping is per pixel. Off-screen pixels still consume cycles but are not written.
- op_empty is sampled only in IDLE. The FIFO is never popped while busy.

Decomposition:
- gpu_op_t stays in the existing shared typedef header, unchanged. Fields used: x, y, width, height, color, mem_en, mem_addr, scale.
- Shared package gpu_pkg holds:
  - the spr_data bit positions (SPR_OPAQUE_BIT=1, SPR_COLOR_BIT=0);
  - the state enum IDLE, LATCH, DRAW, DRAIN.
- One natural sub-module: gpu_rect_walker. It is the dx/dy/row_base/tex_row_base iterator with start/last handshake. Stage B and the FIFO control stay in the top.

Test Plan:
- Solid op {x=0,y=0,w=640,h=480,color=0,mem_en=0} -> exactly 307200 writes, addresses 0..307199 in order, data 0, busy high for 307203 cycles.
- Solid op {x=620,y=470,w=40,h=20,color=1} -> only 20×10 writes, first addr 470*640+620=301420, none with x≥640 or y≥480.
- Sprite op {x=20,y=228,w=34,h=24,mem_en=1,mem_addr=0,scale=0}, ROM texel i = {i[0],i[1]} -> write only on odd texels, spr_addr sequence 0..815, fb_wr_data tracks bit0.
- Sprite op with scale=1, w=4, h=4 -> spr_addr sequence 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3.
- Zero-width op, then a 1×1 op queued -> no writes for the first, pops spaced 3 cycles apart, one write for the second at cycle 3 after its pop.
- rst_n pulled low during DRAW of a 40×40 op, and separately ce held low 5 cycles mid-op -> reset: outputs 0 immediately, no writes after release until a new pop. ce low: write sequence resumes identical, only delayed.
